// File: rtl/pim_pkg.sv
// pim_pkg: shared defaults and read-FSM encoding for the PIM operand loader.
package pim_pkg;
  localparam int PIM_DATA_W = 32;
  localparam int PIM_BLOCK_SIZE = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, RUN = 2'd2} ld_state_t;
endpackage

// File: rtl/pim_operand_bank.sv
// pim_operand_bank: DEPTH x W register file, one sync write port and one async read port.
module pim_operand_bank #(
  parameter int DEPTH = 16,
  parameter int W = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/pim_operand_loader.sv
// pim_operand_loader: ping-pong operand buffer feeding (x, w) pairs to the PIM MAC engine.
module pim_operand_loader
  import pim_pkg::*;
#(
  parameter int BLOCK_SIZE = PIM_BLOCK_SIZE,
  parameter int DATA_W = PIM_DATA_W,
  localparam int IDX_W = $clog2(BLOCK_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_w,
  output logic              mac_start,
  input  logic              mac_busy,
  input  logic              mac_done,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_x,
  output logic [DATA_W-1:0] op_w,
  output logic [15:0]       blocks_issued,
  output logic              err_unexp_done
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCK_SIZE - 1);
  ld_state_t state;
  logic wr_bank, rd_bank;
  logic [IDX_W-1:0] wr_ptr, rd_ptr;
  logic [1:0] bank_full;
  logic [2*DATA_W-1:0] rdata [2];
  logic wr_fire, wr_last, rd_clr;
  assign in_ready = !bank_full[wr_bank];
  assign wr_fire = in_valid && in_ready;
  assign wr_last = wr_fire && wr_ptr == LAST;
  assign rd_clr = state == RUN && mac_done;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    pim_operand_bank #(.DEPTH(BLOCK_SIZE), .W(2*DATA_W)) u_bank (
      .clk(clk),
      .we(wr_fire && wr_bank == 1'(b)),
      .waddr(wr_ptr),
      .wdata({in_x, in_w}),
      .raddr(rd_ptr),
      .rdata(rdata[b])
    );
  end
  assign {op_x, op_w} = rdata[rd_bank];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_bank <= 1'b0;
      wr_ptr <= '0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + 1'b1;
      wr_bank <= wr_bank ^ wr_last;
    end
  // set and clear always hit different banks, so both apply in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) bank_full <= 2'b00;
    else bank_full <= (bank_full | (wr_last ? 2'b01 << wr_bank : 2'b00))
                      & ~(rd_clr ? 2'b01 << rd_bank : 2'b00);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd_bank <= 1'b0;
      rd_ptr <= '0;
      mac_start <= 1'b0;
      op_valid <= 1'b0;
      blocks_issued <= '0;
      err_unexp_done <= 1'b0;
    end else begin
      if (mac_done && state != RUN) err_unexp_done <= 1'b1;
      case (state)
        IDLE:
          if (bank_full[rd_bank] && !mac_busy) begin
            state <= START;
            rd_ptr <= '0;
            mac_start <= 1'b1;
            blocks_issued <= blocks_issued + 1'b1;
          end
        START: begin
          state <= RUN;
          mac_start <= 1'b0;
          op_valid <= 1'b1;
        end
        RUN:
          if (mac_done) begin
            state <= IDLE;
            op_valid <= 1'b0;
            rd_bank <= ~rd_bank;
          end else if (mac_busy && rd_ptr != LAST) rd_ptr <= rd_ptr + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pim_operand_loader.sv
// tb_pim_operand_loader: directed checks of the operand loader against a small MAC engine model.
module tb_pim_operand_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] in_x = '0, in_w = '0, op_x, op_w;
  logic mac_start, mac_busy, mac_done, op_valid, err_unexp_done;
  logic [15:0] blocks_issued;
  logic m_busy, m_done, inj_busy = 1'b0, inj_done = 1'b0, mac_en = 1'b1;
  int mac_len = 16, cnt, nstart, ndone;
  longint unsigned acc;
  logic [31:0] got [$];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  assign mac_busy = m_busy | inj_busy;
  assign mac_done = m_done | inj_done;
  pim_operand_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .mac_start(mac_start), .mac_busy(mac_busy), .mac_done(mac_done), .op_valid(op_valid),
    .op_x(op_x), .op_w(op_w), .blocks_issued(blocks_issued), .err_unexp_done(err_unexp_done)
  );
  // MAC engine model: busy for mac_len cycles after a start, consumes the first 16 pairs
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; cnt <= 0; nstart <= 0; ndone <= 0; acc <= 0;
    end else begin
      m_done <= 1'b0;
      if (mac_start) nstart <= nstart + 1;
      if (mac_start && mac_en) begin
        m_busy <= 1'b1; cnt <= 0; acc <= 0;
      end else if (m_busy) begin
        if (cnt < 16) begin
          acc <= acc + longint'(op_x) * longint'(op_w);
          got.push_back(op_x);
        end
        cnt <= cnt + 1;
        if (cnt == mac_len - 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; ndone <= ndone + 1;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic timeout(input string tag);
    vectors++; miscompares++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask
  task automatic wr(input logic [31:0] x, input logic [31:0] w, output int stall, output logic ld);
    in_valid = 1'b1; in_x = x; in_w = w; stall = 0; ld = 1'b0;
    while (!in_ready && stall < 400) begin ld = mac_done; tick(); stall++; end
    if (stall >= 400) timeout("write");
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_start(input string tag);
    int n = 0;
    while (!mac_start && n < 200) begin tick(); n++; end
    if (n >= 200) timeout(tag);
    else chk(tag, mac_start, 1'b1);
  endtask
  task automatic wait_done(input int target);
    int n = 0;
    while (ndone < target && n < 1000) begin tick(); n++; end
    if (n >= 1000) timeout("mac_done");
  endtask
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; inj_busy = 1'b0; inj_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    got.delete();
  endtask
  initial begin
    int st;
    logic ld;
    // 1: reset and idle
    do_reset();
    repeat (5) tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mac_start", mac_start, 1'b0);
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_blocks", blocks_issued, 16'd0);
    chk("rst_err", err_unexp_done, 1'b0);
    // 2: one block, dot product 2*sum(k^2) = 2992
    for (int k = 0; k < 16; k++) wr(k + 1, 2 * (k + 1), st, ld);
    wait_done(1);
    tick();
    chk("b1_acc", acc, 64'd2992);
    chk("b1_nstart", nstart, 1);
    chk("b1_blocks", blocks_issued, 16'd1);
    chk("b1_op_valid", op_valid, 1'b0);
    chk("b1_count", got.size(), 16);
    for (int k = 0; k < 16 && k < got.size(); k++) chk($sformatf("b1_op_x%0d", k), got[k], k + 1);
    // 3: 48-pair stream against a slow MAC
    got.delete();
    mac_len = 100;
    for (int i = 0; i < 48; i++) begin
      wr(i + 1, i, st, ld);
      if (i == 31) chk("s_ready_low", in_ready, 1'b0);
      if (i == 32) begin
        chk("s_stalled", st > 0, 1'b1);
        chk("s_ready_after_done", ld, 1'b1);
      end
    end
    wait_done(4);
    tick();
    chk("s_blocks", blocks_issued, 16'd4);
    chk("s_count", got.size(), 48);
    for (int i = 0; i < 48 && i < got.size(); i++) chk($sformatf("s_op_x%0d", i), got[i], i + 1);
    // 4: bank-1 fill coincides with bank-0 done
    do_reset();
    mac_en = 1'b0;
    for (int k = 0; k < 16; k++) wr(100 + k, 500 + k, st, ld);
    wait_start("c_start0");
    tick();
    inj_busy = 1'b1;
    for (int k = 0; k < 15; k++) wr(200 + k, 600 + k, st, ld);
    in_valid = 1'b1; in_x = 215; in_w = 615; inj_done = 1'b1; inj_busy = 1'b0;
    chk("c_ready_last", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; inj_done = 1'b0;
    chk("c_bank_full", dut.bank_full, 2'b10);
    chk("c_no_start_yet", mac_start, 1'b0);
    tick();
    chk("c_start1", mac_start, 1'b1);
    tick();
    chk("c_op_valid", op_valid, 1'b1);
    chk("c_op_x0", op_x, 32'd200);
    chk("c_op_w0", op_w, 32'd600);
    chk("c_blocks", blocks_issued, 16'd2);
    // 5: reset in RUN at rd_ptr 7
    inj_busy = 1'b1; inj_done = 1'b1;
    tick();
    do_reset();
    mac_en = 1'b1; mac_len = 16;
    for (int k = 0; k < 16; k++) wr(k + 1, 1, st, ld);
    st = 0;
    while (!(op_valid && op_x == 8) && st < 100) begin tick(); st++; end
    chk("r_rd_ptr7", dut.rd_ptr, 4'd7);
    rst = 1'b1;
    #1;
    chk("r_in_ready", in_ready, 1'b1);
    chk("r_mac_start", mac_start, 1'b0);
    chk("r_op_valid", op_valid, 1'b0);
    chk("r_blocks", blocks_issued, 16'd0);
    chk("r_err", err_unexp_done, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) wr(k + 1, 1, st, ld);
    repeat (4) tick();
    chk("r_no_start15", nstart, 0);
    wr(16, 1, st, ld);
    wait_start("r_start16");
    wait_done(1);
    // 6: unexpected done in IDLE
    do_reset();
    inj_busy = 1'b1;
    for (int k = 0; k < 16; k++) wr(k, k, st, ld);
    repeat (3) tick();
    chk("e_held", mac_start, 1'b0);
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    chk("e_err_set", err_unexp_done, 1'b1);
    chk("e_bank_full", dut.bank_full, 2'b01);
    chk("e_op_valid", op_valid, 1'b0);
    tick();
    chk("e_err_sticky", err_unexp_done, 1'b1);
    inj_busy = 1'b0;
    wait_start("e_start");
    wait_done(1);
    tick();
    chk("e_err_after", err_unexp_done, 1'b1);
    chk("e_bank_clear", dut.bank_full, 2'b00);
    chk("e_blocks", blocks_issued, 16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
